// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-bus signal bundle for mem_bus_arbiter.
// The arbiter uses the slave view; the datapath/bus environment uses the master view.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch requester
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_data_ok;
    logic [DATA_W-1:0] i_rdata;

    // data requester
    logic              d_req;
    logic              d_wr;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_data_ok;
    logic [DATA_W-1:0] d_rdata;

    // shared memory bus
    logic              bus_req;
    logic              bus_wr;
    logic [1:0]        bus_size;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DATA_W-1:0] bus_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_data_ok, i_rdata,
        input  d_req, d_wr, d_size, d_addr, d_wdata,
        output d_data_ok, d_rdata,
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_data_ok, i_rdata,
        output d_req, d_wr, d_size, d_addr, d_wdata,
        input  d_data_ok, d_rdata,
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between instruction fetch and data access, one transaction
// in flight; data side has priority, bounded by a streak counter so fetch cannot starve.
module mem_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic             clk,
    input  logic             reset,
    mem_bus_arbiter_if.slave bif
);
    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_D_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_I_ADDR = 3'd1,
        ST_I_DATA = 3'd2,
        ST_D_ADDR = 3'd3,
        ST_D_DATA = 3'd4
    } state_t;

    state_t              state_r;
    logic [STREAK_W-1:0] streak_r;
    logic                bus_req_r;
    logic                bus_wr_r;
    logic [1:0]          bus_size_r;
    logic [ADDR_W-1:0]   bus_addr_r;
    logic [DATA_W-1:0]   bus_wdata_r;
    logic                grant_d_s;
    logic                grant_i_s;

    // Arbitration decision, only meaningful while the bus is free.
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (bif.d_req && (!bif.i_req || (streak_r < MAX_STREAK))) begin
                grant_d_s = 1'b1;
            end else if (bif.i_req) begin
                grant_i_s = 1'b1;
            end else begin
                grant_d_s = 1'b0;
                grant_i_s = 1'b0;
            end
        end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end
    end

    // Transaction sequencer: latches the owner's fields and drives the bus handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            streak_r    <= {STREAK_W{1'b0}};
            bus_req_r   <= 1'b0;
            bus_wr_r    <= 1'b0;
            bus_size_r  <= 2'd0;
            bus_addr_r  <= {ADDR_W{1'b0}};
            bus_wdata_r <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_d_s) begin
                        bus_req_r   <= 1'b1;
                        bus_wr_r    <= bif.d_wr;
                        bus_size_r  <= bif.d_size;
                        bus_addr_r  <= bif.d_addr;
                        bus_wdata_r <= bif.d_wdata;
                        state_r     <= ST_D_ADDR;
                        // streak only counts data wins that made a fetch wait
                        if (bif.i_req) begin
                            streak_r <= (streak_r == MAX_STREAK) ? MAX_STREAK : (streak_r + STREAK_ONE);
                        end else begin
                            streak_r <= {STREAK_W{1'b0}};
                        end
                    end else if (grant_i_s) begin
                        bus_req_r   <= 1'b1;
                        bus_wr_r    <= 1'b0;
                        bus_size_r  <= 2'd2;
                        bus_addr_r  <= bif.i_addr;
                        bus_wdata_r <= {DATA_W{1'b0}};
                        state_r     <= ST_I_ADDR;
                        streak_r    <= {STREAK_W{1'b0}};
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_I_ADDR, ST_D_ADDR: begin
                    if (bif.bus_addr_ok) begin
                        bus_req_r <= 1'b0;
                        state_r   <= (state_r == ST_I_ADDR) ? ST_I_DATA : ST_D_DATA;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_I_DATA, ST_D_DATA: begin
                    if (bif.bus_data_ok) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bus_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign bif.bus_req   = bus_req_r;
    assign bif.bus_wr    = bus_wr_r;
    assign bif.bus_size  = bus_size_r;
    assign bif.bus_addr  = bus_addr_r;
    assign bif.bus_wdata = bus_wdata_r;

    // Responses are forwarded in the same cycle so the hazard logic can release a stall at once.
    assign bif.i_data_ok = (state_r == ST_I_DATA) && bif.bus_data_ok;
    assign bif.d_data_ok = (state_r == ST_D_DATA) && bif.bus_data_ok;
    assign bif.i_rdata   = bif.bus_rdata;
    assign bif.d_rdata   = bif.bus_rdata;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized scoreboard bench for mem_bus_arbiter: a transaction-level reference model
// predicts bus grants and requester responses; a negedge monitor compares them.
module tb_mem_bus_arbiter;
    localparam int MAX_D_STREAK = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAX_D_STREAK)) dut (
        .clk   (clk),
        .reset (reset),
        .bif   (bif.slave)
    );

    typedef struct packed {
        logic        is_d;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_txn_t;

    typedef struct packed {
        logic        is_d;
        logic [31:0] rdata;
    } resp_t;

    bus_txn_t exp_bus[$];
    resp_t    exp_resp[$];
    bus_txn_t mon_bt;
    resp_t    mon_rt;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: one transaction at a time, data wins unless fetch waited MAX times
    bit busy, addr_done, owner_d;
    int d_wins_over_waiting_fetch;
    int resp_delay;
    bit i_pend, d_pend, issue_en, first_fetch;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        bus_txn_t t;
        resp_t    r;
        @(posedge clk);
        #1;
        // outcome of the edge just taken, from the inputs that were on the bus before it
        if (!busy) begin
            if (bif.d_req || bif.i_req) begin
                busy      = 1'b1;
                addr_done = 1'b0;
                if (bif.d_req && (!bif.i_req || d_wins_over_waiting_fetch < MAX_D_STREAK)) begin
                    owner_d = 1'b1;
                    d_wins_over_waiting_fetch = bif.i_req ? d_wins_over_waiting_fetch + 1 : 0;
                    t = '{is_d: 1'b1, wr: bif.d_wr, size: bif.d_size, addr: bif.d_addr, wdata: bif.d_wdata};
                end else begin
                    owner_d = 1'b0;
                    d_wins_over_waiting_fetch = 0;
                    t = '{is_d: 1'b0, wr: 1'b0, size: 2'd2, addr: bif.i_addr, wdata: 32'h0};
                end
                exp_bus.push_back(t);
            end
        end else if (!addr_done) begin
            if (bif.bus_addr_ok) begin
                addr_done  = 1'b1;
                resp_delay = int'($urandom_range(0, 3));
            end
        end else if (bif.bus_data_ok) begin
            busy = 1'b0;
            if (owner_d) d_pend = 1'b0;
            else         i_pend = 1'b0;
        end

        // fetch requester
        if (!i_pend && issue_en && $urandom_range(0, 99) < 60) begin
            i_pend     = 1'b1;
            bif.i_req  = 1'b1;
            bif.i_addr = first_fetch ? 32'hBFC0_0000 : ($urandom() & 32'hFFFF_FFFC);
            first_fetch = 1'b0;
        end else if (!i_pend) begin
            bif.i_req = 1'b0;
        end else if (busy && !owner_d && $urandom_range(0, 7) == 0) begin
            bif.i_addr = $urandom();
            bif.i_req  = 1'($urandom_range(0, 1));
        end

        // data requester
        if (!d_pend && issue_en && $urandom_range(0, 99) < 80) begin
            d_pend      = 1'b1;
            bif.d_req   = 1'b1;
            bif.d_wr    = 1'($urandom_range(0, 1));
            bif.d_size  = 2'($urandom_range(0, 2));
            bif.d_addr  = $urandom();
            bif.d_wdata = $urandom();
        end else if (!d_pend) begin
            bif.d_req = 1'b0;
        end else if (busy && owner_d && $urandom_range(0, 7) == 0) begin
            bif.d_addr  = $urandom();
            bif.d_wdata = $urandom();
            bif.d_req   = 1'($urandom_range(0, 1));
        end

        // bus slave
        bif.bus_addr_ok = 1'b0;
        bif.bus_data_ok = 1'b0;
        if (!busy) begin
            bif.bus_addr_ok = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) begin
                bif.bus_data_ok = 1'b1;
                bif.bus_rdata   = $urandom();
            end
        end else if (!addr_done) begin
            bif.bus_addr_ok = ($urandom_range(0, 2) == 0);
        end else if (resp_delay == 0) begin
            bif.bus_data_ok = 1'b1;
            bif.bus_rdata   = $urandom();
            r = '{is_d: owner_d, rdata: bif.bus_rdata};
            exp_resp.push_back(r);
        end else begin
            resp_delay--;
        end
    endtask

    // monitor: compares every cycle against the scoreboard heads
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_bus_req", bif.bus_req, 1'b0);
                chk("rst_i_data_ok", bif.i_data_ok, 1'b0);
                chk("rst_d_data_ok", bif.d_data_ok, 1'b0);
            end else begin
                if (exp_bus.size() > 0) begin
                    mon_bt = exp_bus[0];
                    chk("bus_req", bif.bus_req, 1'b1);
                    chk("bus_wr", bif.bus_wr, mon_bt.wr);
                    chk("bus_size", bif.bus_size, mon_bt.size);
                    chk("bus_addr", bif.bus_addr, mon_bt.addr);
                    chk("bus_wdata", bif.bus_wdata, mon_bt.wdata);
                    if (bif.bus_addr_ok) void'(exp_bus.pop_front());
                end else begin
                    chk("bus_req_quiet", bif.bus_req, 1'b0);
                end
                if (exp_resp.size() > 0) begin
                    mon_rt = exp_resp.pop_front();
                    chk("i_data_ok", bif.i_data_ok, !mon_rt.is_d);
                    chk("d_data_ok", bif.d_data_ok, mon_rt.is_d);
                    if (mon_rt.is_d) chk("d_rdata", bif.d_rdata, mon_rt.rdata);
                    else             chk("i_rdata", bif.i_rdata, mon_rt.rdata);
                end else begin
                    chk("i_data_ok_quiet", bif.i_data_ok, 1'b0);
                    chk("d_data_ok_quiet", bif.d_data_ok, 1'b0);
                end
            end
        end
    end

    initial begin
        bif.i_req = 1'b0; bif.i_addr = 32'h0;
        bif.d_req = 1'b0; bif.d_wr = 1'b0; bif.d_size = 2'd0; bif.d_addr = 32'h0; bif.d_wdata = 32'h0;
        bif.bus_addr_ok = 1'b0; bif.bus_data_ok = 1'b0; bif.bus_rdata = 32'h0;
        busy = 1'b0; addr_done = 1'b0; owner_d = 1'b0;
        d_wins_over_waiting_fetch = 0; resp_delay = 0;
        i_pend = 1'b0; d_pend = 1'b0; issue_en = 1'b1; first_fetch = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_bus_wr", bif.bus_wr, 1'b0);
        chk("reset_bus_size", bif.bus_size, 2'd0);
        chk("reset_bus_addr", bif.bus_addr, 32'h0);
        chk("reset_bus_wdata", bif.bus_wdata, 32'h0);
        reset = 1'b0;

        repeat (3000) step();

        // reset while a data access waits for its response; the late response must vanish
        begin
            int k;
            k = 0;
            while (k < 2000 && !(busy && addr_done && owner_d && resp_delay > 0)) begin
                step();
                k++;
            end
            chk("reached_d_data", {63'h0, busy && addr_done && owner_d}, 64'h1);
        end
        reset = 1'b1;
        exp_bus.delete();
        exp_resp.delete();
        busy = 1'b0; addr_done = 1'b0;
        d_wins_over_waiting_fetch = 0;
        i_pend = 1'b0; d_pend = 1'b0;
        bif.i_req = 1'b0; bif.d_req = 1'b0;
        bif.bus_addr_ok = 1'b0;
        bif.bus_data_ok = 1'b1;
        bif.bus_rdata   = 32'h1234_5678;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bif.bus_data_ok = 1'b1;
        @(posedge clk);
        #1;
        bif.bus_data_ok = 1'b0;
        chk("post_reset_bus_req", bif.bus_req, 1'b0);

        repeat (1500) step();

        issue_en = 1'b0;
        begin
            int k;
            k = 0;
            while (k < 300 && (busy || i_pend || d_pend)) begin
                step();
                k++;
            end
        end
        chk("drain_idle", {61'h0, busy, i_pend, d_pend}, 64'h0);
        @(negedge clk);
        chk("exp_bus_empty", 64'(exp_bus.size()), 64'h0);
        chk("exp_resp_empty", 64'(exp_resp.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
